sensor_stream_packer: RTL and testbench
=======================================

# sensor_stream_packer

Consumer end of the sensor stream interface. Watches the eight `sensor_stream_ready` flags, captures one ready stream at a time with a round-robin arbiter, and acknowledges the capture to the producer. It then serializes the captured sample into a framed byte sequence on a valid/ready byte port feeding the Bluetooth UART transmitter.

## Interface
- `HEADER_TAG`, default 4'hA: upper nibble of every frame header byte.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- `sensor_stream0`  in  32  stream 0 sample.
- `sensor_stream1`..`sensor_stream7`  in  16 each  stream 1–7 samples.
- `sensor_stream_ready`  in  8  bit i = stream i holds a new sample (level).
- `stream_enable`  in  8  bit i = stream i may be served; disabled streams are ignored and never acked.
- `sensor_stream_ack`  out  8  one-hot, one-cycle pulse: stream i captured.
- `out_byte`  out  8  current frame byte.
- `out_valid`  out  1  `out_byte` is valid.
- `out_ready`  in  1  downstream accepts `out_byte` this cycle.
- `busy`  out  1  high whenever state is not SCAN.
- `frame_count`  out  16  frames fully sent since reset; wraps 0xFFFF→0x0000.

## Operation
- Eligible set: `E = sensor_stream_ready & stream_enable`.
- States: SCAN, SEND_HDR, SEND_DATA.
- SCAN:
  - `out_valid`=0.
  - If E≠0, select the first set bit of E searching upward from `rr_ptr` with wrap (7→0).
  - Latch that stream's data into a 32-bit shift register. Streams 1–7 are zero-extended into bits [15:0].
  - Latch `id`, set `byte_cnt` (4 for stream 0, else 2), pulse `sensor_stream_ack[id]`, and go to SEND_HDR.
  - If E=0, stay in SCAN.
- SEND_HDR:
  - `out_byte = {HEADER_TAG, 1'b0, id[2:0]}`, `out_valid`=1.
  - On `out_ready`, go to SEND_DATA.
- SEND_DATA:
  - Data goes out MSB first: stream 0 sends bits [31:24], [23:16], [15:8], [7:0]; streams 1–7 send [15:8], [7:0].
  - Each accepted byte decrements `byte_cnt`.
  - On acceptance of the last byte: increment `frame_count`, set `rr_ptr = id+1` (mod 8), go to SCAN.
- Handshake: a byte transfers only in a cycle with `out_valid` && `out_ready`. While `out_valid`=1 and `out_ready`=0, `out_byte` and state are held stable.
- Capture is atomic: producer data changes after capture do not affect the frame in flight.
- `stream_enable` and ready changes during a frame take effect at the next SCAN.
- Producer contract: the producer deasserts `ready[i]` within 1 cycle of seeing `ack[i]`. The packer does not rescan before then, because the minimum frame is 3 transfer cycles.
- Reset (`reset`=0 at any edge, including mid-frame):
  - state=SCAN, `rr_ptr`=0, `out_valid`=0, `out_byte`=8'h00, `sensor_stream_ack`=8'h00, `frame_count`=0, `busy`=0.
  - A partial frame is abandoned; no ack is reissued.

## Timing
- All outputs are registered.
- Capture latency: if SCAN sees E≠0 at edge t, then at t+1 `sensor_stream_ack[id]`=1 (for exactly one cycle), `out_valid`=1, and `out_byte`=header.
- With `out_ready` held high:
  - stream 0 frame: 5 cycles of valid.
  - streams 1–7: 3 cycles of valid.
- `frame_count` updates on the edge that accepts the last byte.
- After the last byte is accepted, there is one SCAN cycle with `out_valid`=0 before the next header. Back-to-back throughput is 4 cycles per 16-bit frame and 6 cycles per stream-0 frame.
- `busy` is high from the header cycle through the last data cycle.

## Test plan
- Reset/idle: hold `reset`=0 for 5 cycles with all ready bits high → `out_valid`=0, `ack`=0, `frame_count`=0. Release with E=0 → remains idle, `busy`=0.
- Stream 0 frame: `sensor_stream0`=32'hDEADBEEF, `ready`=8'h01, `enable`=8'hFF, `out_ready`=1 → `ack`=8'h01 for one cycle; bytes A0, DE, AD, BE, EF; `frame_count`=1.
- Round-robin: `ready`=8'h84 held (bits 2 and 7), streams 2/7 = 16'h1234/16'h5678, producer clears the acked bit then reasserts it → frame order A2 12 34, A7 56 78, A2 12 34 (after wrap).
- Backpressure: stream 3=16'hCAFE. Drop `out_ready` for 4 cycles after the header and for 2 cycles mid-data; change `sensor_stream3` to 16'h0000 after ack → stream is A3 CA FE, with bytes stable while stalled.
- Enable mask: `ready`=8'hFF, `enable`=8'h20 → only stream 5 served (header A5); `ack` never asserts for other bits.
- Mid-frame reset: assert `reset`=0 after the second byte of a stream 0 frame → next cycle `out_valid`=0, `frame_count` unchanged/cleared to 0, `rr_ptr`=0. After release, stream 0 ready → a fresh full frame starting with header A0.

Source files
------------

// File: rtl/sensor_stream_packer.sv
// Round-robin consumer of eight sensor streams. Each captured sample goes out
// as a framed byte sequence (header, then data MSB first) on a valid/ready port.
module sensor_stream_packer #(
   parameter logic [3:0] HEADER_TAG = 4'hA
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] sensor_stream0,
   input  logic [15:0] sensor_stream1,
   input  logic [15:0] sensor_stream2,
   input  logic [15:0] sensor_stream3,
   input  logic [15:0] sensor_stream4,
   input  logic [15:0] sensor_stream5,
   input  logic [15:0] sensor_stream6,
   input  logic [15:0] sensor_stream7,
   input  logic [7:0]  sensor_stream_ready,
   input  logic [7:0]  stream_enable,
   output logic [7:0]  sensor_stream_ack,
   output logic [7:0]  out_byte,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic [15:0] frame_count
);

   typedef enum logic [1:0] {ST_SCAN, ST_SEND_HDR, ST_SEND_DATA} state_t;

   state_t      state, state_nxt;
   logic [31:0] shreg;
   logic [2:0]  id;
   logic [2:0]  byte_cnt;
   logic [2:0]  rr_ptr;

   logic [7:0]  eligible;
   logic        grant_vld;
   logic [2:0]  grant_id;
   logic [31:0] grant_data;
   logic        xfer;
   logic        last_byte;
   logic [1:0]  hdr_sel;
   logic [1:0]  data_sel;

   logic        out_valid_nxt;
   logic [7:0]  out_byte_nxt;
   logic [7:0]  ack_nxt;

   assign eligible  = sensor_stream_ready & stream_enable;
   assign xfer      = out_valid & out_ready;
   assign last_byte = (byte_cnt == 3'd1);
   assign hdr_sel   = 2'(byte_cnt - 3'd1);
   assign data_sel  = 2'(byte_cnt - 3'd2);
   assign busy      = (state != ST_SCAN);

   // Walk downward so the smallest offset from rr_ptr is the last (winning) write.
   always_comb begin
      logic [2:0] idx;
      grant_vld = 1'b0;
      grant_id  = 3'd0;
      idx       = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         idx = rr_ptr + 3'(k);
         if (eligible[idx]) begin
            grant_vld = 1'b1;
            grant_id  = idx;
         end
      end
   end

   always_comb begin
      case (grant_id)
         3'd0:    grant_data = sensor_stream0;
         3'd1:    grant_data = {16'h0000, sensor_stream1};
         3'd2:    grant_data = {16'h0000, sensor_stream2};
         3'd3:    grant_data = {16'h0000, sensor_stream3};
         3'd4:    grant_data = {16'h0000, sensor_stream4};
         3'd5:    grant_data = {16'h0000, sensor_stream5};
         3'd6:    grant_data = {16'h0000, sensor_stream6};
         default: grant_data = {16'h0000, sensor_stream7};
      endcase
   end

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_SCAN:      if (grant_vld) state_nxt = ST_SEND_HDR;
         ST_SEND_HDR:  if (xfer) state_nxt = ST_SEND_DATA;
         ST_SEND_DATA: if (xfer && last_byte) state_nxt = ST_SCAN;
         default:      state_nxt = ST_SCAN;
      endcase
   end

   // Next values of the registered outputs; a stalled byte simply holds.
   always_comb begin
      out_valid_nxt = out_valid;
      out_byte_nxt  = out_byte;
      ack_nxt       = 8'h00;
      case (state)
         ST_SCAN: begin
            out_valid_nxt = 1'b0;
            out_byte_nxt  = 8'h00;
            if (grant_vld) begin
               out_valid_nxt = 1'b1;
               out_byte_nxt  = {HEADER_TAG, 1'b0, grant_id};
               ack_nxt       = 8'h01 << grant_id;
            end
         end
         ST_SEND_HDR: begin
            if (xfer) out_byte_nxt = shreg[{hdr_sel, 3'b000} +: 8];
         end
         ST_SEND_DATA: begin
            if (xfer) begin
               if (last_byte) begin
                  out_valid_nxt = 1'b0;
                  out_byte_nxt  = 8'h00;
               end else begin
                  out_byte_nxt = shreg[{data_sel, 3'b000} +: 8];
               end
            end
         end
         default: begin
            out_valid_nxt = 1'b0;
            out_byte_nxt  = 8'h00;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state             <= ST_SCAN;
         rr_ptr            <= 3'd0;
         out_valid         <= 1'b0;
         out_byte          <= 8'h00;
         sensor_stream_ack <= 8'h00;
         frame_count       <= 16'h0000;
      end else begin
         state             <= state_nxt;
         out_valid         <= out_valid_nxt;
         out_byte          <= out_byte_nxt;
         sensor_stream_ack <= ack_nxt;
         if (state == ST_SEND_DATA && xfer && last_byte) begin
            frame_count <= frame_count + 16'd1;
            rr_ptr      <= id + 3'd1;
         end
      end
   end

   // NOTE: the capture registers are left unreset; each one is rewritten on
   // capture before any state reads it, so a reset would add nothing.
   always_ff @(posedge clock) begin
      if (state == ST_SCAN && grant_vld) begin
         shreg    <= grant_data;
         id       <= grant_id;
         byte_cnt <= (grant_id == 3'd0) ? 3'd4 : 3'd2;
      end else if (state == ST_SEND_DATA && xfer) begin
         byte_cnt <= byte_cnt - 3'd1;
      end
   end

endmodule

// File: tb/tb_sensor_stream_packer.sv
// Directed bench for sensor_stream_packer: inputs change on the falling edge,
// outputs are sampled on the falling edge against hand-computed values.
module tb_sensor_stream_packer;

   logic        clock;
   logic        reset;
   logic [31:0] sensor_stream0;
   logic [15:0] sensor_stream1, sensor_stream2, sensor_stream3, sensor_stream4;
   logic [15:0] sensor_stream5, sensor_stream6, sensor_stream7;
   logic [7:0]  sensor_stream_ready;
   logic [7:0]  stream_enable;
   logic [7:0]  sensor_stream_ack;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic [15:0] frame_count;

   int checks = 0;
   int errors = 0;

   sensor_stream_packer #(.HEADER_TAG(4'hA)) dut (
      .clock               (clock),
      .reset               (reset),
      .sensor_stream0      (sensor_stream0),
      .sensor_stream1      (sensor_stream1),
      .sensor_stream2      (sensor_stream2),
      .sensor_stream3      (sensor_stream3),
      .sensor_stream4      (sensor_stream4),
      .sensor_stream5      (sensor_stream5),
      .sensor_stream6      (sensor_stream6),
      .sensor_stream7      (sensor_stream7),
      .sensor_stream_ready (sensor_stream_ready),
      .stream_enable       (stream_enable),
      .sensor_stream_ack   (sensor_stream_ack),
      .out_byte            (out_byte),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .busy                (busy),
      .frame_count         (frame_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance to the next falling edge and check the byte port and ack.
   task automatic step(input string tag, input logic exp_valid, input logic [7:0] exp_byte,
                       input logic [7:0] exp_ack);
      @(negedge clock);
      check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
      if (exp_valid) check({tag, "_byte"}, {24'd0, out_byte}, {24'd0, exp_byte});
      check({tag, "_ack"}, {24'd0, sensor_stream_ack}, {24'd0, exp_ack});
   endtask

   initial begin
      reset               = 1'b0;
      sensor_stream0      = 32'h0;
      sensor_stream1      = 16'h1111;
      sensor_stream2      = 16'h1234;
      sensor_stream3      = 16'h3333;
      sensor_stream4      = 16'h4444;
      sensor_stream5      = 16'h5A5A;
      sensor_stream6      = 16'h6666;
      sensor_stream7      = 16'h5678;
      sensor_stream_ready = 8'hFF;
      stream_enable       = 8'hFF;
      out_ready           = 1'b1;

      // Reset held with every stream ready.
      repeat (5) @(negedge clock);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_byte", {24'd0, out_byte}, 32'h00);
      check("rst_ack", {24'd0, sensor_stream_ack}, 32'h00);
      check("rst_fc", {16'd0, frame_count}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);

      // Release with nothing eligible: stays idle.
      reset = 1'b1;
      sensor_stream_ready = 8'h00;
      step("idle0", 1'b0, 8'h00, 8'h00);
      step("idle1", 1'b0, 8'h00, 8'h00);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Stream 0 frame.
      sensor_stream0 = 32'hDEADBEEF;
      sensor_stream_ready = 8'h01;
      step("s0_hdr", 1'b1, 8'hA0, 8'h01);
      check("s0_busy", {31'd0, busy}, 32'd1);
      sensor_stream_ready = 8'h00;
      step("s0_d0", 1'b1, 8'hDE, 8'h00);
      step("s0_d1", 1'b1, 8'hAD, 8'h00);
      step("s0_d2", 1'b1, 8'hBE, 8'h00);
      check("s0_fc_mid", {16'd0, frame_count}, 32'd0);
      step("s0_d3", 1'b1, 8'hEF, 8'h00);
      step("s0_end", 1'b0, 8'h00, 8'h00);
      check("s0_fc", {16'd0, frame_count}, 32'd1);
      check("s0_busy_end", {31'd0, busy}, 32'd0);

      // Round robin between streams 2 and 7 (rr_ptr is now 1).
      sensor_stream_ready = 8'h84;
      step("rr1_hdr", 1'b1, 8'hA2, 8'h04);
      sensor_stream_ready = 8'h80;
      step("rr1_d0", 1'b1, 8'h12, 8'h00);
      step("rr1_d1", 1'b1, 8'h34, 8'h00);
      step("rr1_end", 1'b0, 8'h00, 8'h00);
      sensor_stream_ready = 8'h84;
      step("rr2_hdr", 1'b1, 8'hA7, 8'h80);
      sensor_stream_ready = 8'h04;
      step("rr2_d0", 1'b1, 8'h56, 8'h00);
      step("rr2_d1", 1'b1, 8'h78, 8'h00);
      step("rr2_end", 1'b0, 8'h00, 8'h00);
      sensor_stream_ready = 8'h84;
      step("rr3_hdr", 1'b1, 8'hA2, 8'h04);
      sensor_stream_ready = 8'h00;
      step("rr3_d0", 1'b1, 8'h12, 8'h00);
      step("rr3_d1", 1'b1, 8'h34, 8'h00);
      step("rr3_end", 1'b0, 8'h00, 8'h00);
      check("rr_fc", {16'd0, frame_count}, 32'd4);

      // Backpressure on stream 3 with the producer changing data after ack.
      sensor_stream3 = 16'hCAFE;
      sensor_stream_ready = 8'h08;
      step("bp_hdr", 1'b1, 8'hA3, 8'h08);
      out_ready = 1'b0;
      sensor_stream_ready = 8'h00;
      sensor_stream3 = 16'h0000;
      for (int i = 0; i < 4; i++) step($sformatf("bp_hstall%0d", i), 1'b1, 8'hA3, 8'h00);
      check("bp_busy", {31'd0, busy}, 32'd1);
      out_ready = 1'b1;
      step("bp_d0", 1'b1, 8'hCA, 8'h00);
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) step($sformatf("bp_dstall%0d", i), 1'b1, 8'hCA, 8'h00);
      out_ready = 1'b1;
      step("bp_d1", 1'b1, 8'hFE, 8'h00);
      step("bp_end", 1'b0, 8'h00, 8'h00);
      check("bp_fc", {16'd0, frame_count}, 32'd5);

      // Enable mask: only stream 5 may be served.
      sensor_stream_ready = 8'hFF;
      stream_enable = 8'h20;
      step("en_hdr", 1'b1, 8'hA5, 8'h20);
      sensor_stream_ready = 8'hDF;
      step("en_d0", 1'b1, 8'h5A, 8'h00);
      step("en_d1", 1'b1, 8'h5A, 8'h00);
      step("en_end", 1'b0, 8'h00, 8'h00);
      step("en_idle0", 1'b0, 8'h00, 8'h00);
      step("en_idle1", 1'b0, 8'h00, 8'h00);
      check("en_fc", {16'd0, frame_count}, 32'd6);

      // Mid-frame reset on a stream 0 frame (rr_ptr is 6 beforehand).
      sensor_stream_ready = 8'h00;
      stream_enable = 8'hFF;
      sensor_stream0 = 32'h11223344;
      @(negedge clock);
      sensor_stream_ready = 8'h01;
      step("mr_hdr", 1'b1, 8'hA0, 8'h01);
      sensor_stream_ready = 8'h00;
      step("mr_d0", 1'b1, 8'h11, 8'h00);
      step("mr_d1", 1'b1, 8'h22, 8'h00);
      reset = 1'b0;
      @(negedge clock);
      check("mr_valid", {31'd0, out_valid}, 32'd0);
      check("mr_byte", {24'd0, out_byte}, 32'h00);
      check("mr_ack", {24'd0, sensor_stream_ack}, 32'h00);
      check("mr_fc", {16'd0, frame_count}, 32'd0);
      check("mr_busy", {31'd0, busy}, 32'd0);

      // Streams 0 and 7 both ready: a cleared rr_ptr must pick stream 0.
      reset = 1'b1;
      sensor_stream_ready = 8'h81;
      step("fr_hdr", 1'b1, 8'hA0, 8'h01);
      sensor_stream_ready = 8'h80;
      step("fr_d0", 1'b1, 8'h11, 8'h00);
      step("fr_d1", 1'b1, 8'h22, 8'h00);
      step("fr_d2", 1'b1, 8'h33, 8'h00);
      step("fr_d3", 1'b1, 8'h44, 8'h00);
      step("fr_end", 1'b0, 8'h00, 8'h00);
      sensor_stream_ready = 8'h00;
      check("fr_fc", {16'd0, frame_count}, 32'd1);
      step("fr_idle", 1'b0, 8'h00, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
